// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package nibble_serial_subtractor_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Slice counter width: max(1, clog2(WIDTH/SLICE_W)).
  function automatic int unsigned cnt_width(input int unsigned width);
    int unsigned nib;
    nib = width / SLICE_W;
    return (nib <= 1) ? 1 : $clog2(nib);
  endfunction

endpackage

// File: rtl/nibble_serial_subtractor_sub4_borrow_la.sv
// 4-bit borrow-lookahead subtract slice: diff = a - b - borrow_in.
module sub4_borrow_la (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       borrow_i,
  output logic [3:0] diff_o,
  output logic       borrow_o
);

  logic [3:0] p;
  logic [3:0] g;
  logic [4:0] c;

  // Subtraction as a + ~b + ~borrow, with CLA-style carry terms.
  assign p = a_i ^ ~b_i;
  assign g = a_i & ~b_i;

  assign c[0] = ~borrow_i;
  assign c[1] = g[0] | (p[0] & c[0]);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c[0]);
  assign c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & c[0]);

  assign diff_o   = p ^ c[3:0];
  assign borrow_o = ~c[4];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial subtractor: diff = a - b - borrow, one 4-bit slice per clock.
// Optional signed overflow flag enabled by defining NIBBLE_SUB_OVERFLOW_EN.
module nibble_serial_subtractor
  import nibble_serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             borrow_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_o,
  output logic             zero_o,
  output logic             overflow_o
);

  localparam int unsigned NIB   = WIDTH / SLICE_W;
  localparam int unsigned CNT_W = cnt_width(WIDTH);
  localparam int unsigned OFF_W = CNT_W + 2;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic               borrow_q;
  logic [WIDTH-1:0]   diff_q;
  logic               ready_q;
  logic               valid_q;
  logic [WIDTH-1:0]   diff_out_q;
  logic               borrow_out_q;
  logic               zero_q;

  logic [OFF_W-1:0]   bit_off;
  logic [SLICE_W-1:0] a_slice;
  logic [SLICE_W-1:0] b_slice;
  logic [SLICE_W-1:0] slice_diff;
  logic               slice_borrow;
  logic [WIDTH-1:0]   diff_d;
  logic               last_slice;

  // Select the active slice and merge its result into the running difference.
  always_comb begin
    bit_off    = {cnt_q, 2'b00};
    a_slice    = a_q[bit_off +: SLICE_W];
    b_slice    = b_q[bit_off +: SLICE_W];
    diff_d     = diff_q;
    diff_d[bit_off +: SLICE_W] = slice_diff;
    last_slice = (cnt_q == CNT_W'(NIB - 1));
  end

  sub4_borrow_la u_slice (
    .a_i      (a_slice),
    .b_i      (b_slice),
    .borrow_i (borrow_q),
    .diff_o   (slice_diff),
    .borrow_o (slice_borrow)
  );

`ifdef NIBBLE_SUB_OVERFLOW_EN
  logic ovf_q;
  logic ovf_d;

  assign ovf_d = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (diff_d[WIDTH-1] ^ a_q[WIDTH-1]);

  // Overflow flag captured alongside the other result flags on entry to DONE.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_q <= 1'b0;
    end else if (state_q == RUN && last_slice) begin
      ovf_q <= ovf_d;
    end
  end

  assign overflow_o = ovf_q;
`else
  assign overflow_o = 1'b0;
`endif

  // Control FSM, operand/diff registers and registered result outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      borrow_q     <= 1'b0;
      diff_q       <= '0;
      ready_q      <= 1'b1;
      valid_q      <= 1'b0;
      diff_out_q   <= '0;
      borrow_out_q <= 1'b0;
      zero_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (valid_i && ready_q) begin
            a_q      <= a_i;
            b_q      <= b_i;
            borrow_q <= borrow_i;
            cnt_q    <= '0;
            diff_q   <= '0;
            ready_q  <= 1'b0;
            state_q  <= RUN;
          end
        end
        RUN: begin
          diff_q   <= diff_d;
          borrow_q <= slice_borrow;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_slice) begin
            diff_out_q   <= diff_d;
            borrow_out_q <= slice_borrow;
            zero_q       <= (diff_d == '0);
            valid_q      <= 1'b1;
            state_q      <= DONE;
          end
        end
        DONE: begin
          if (ready_i) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready_o  = ready_q;
  assign valid_o  = valid_q;
  assign diff_o   = diff_out_q;
  assign borrow_o = borrow_out_q;
  assign zero_o   = zero_q;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor (WIDTH=16), directed and random.
module tb_nibble_serial_subtractor;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned NIB   = WIDTH / 4;

  logic             clk_i;
  logic             rst_ni;
  logic             valid_i;
  logic             ready_o;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic             borrow_i;
  logic             valid_o;
  logic             ready_i;
  logic [WIDTH-1:0] diff_o;
  logic             borrow_o;
  logic             zero_o;
  logic             overflow_o;

  int unsigned passed;
  int unsigned failed;
  int unsigned total;

  nibble_serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .a_i        (a_i),
    .b_i        (b_i),
    .borrow_i   (borrow_i),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .diff_o     (diff_o),
    .borrow_o   (borrow_o),
    .zero_o     (zero_o),
    .overflow_o (overflow_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the full-precision difference.
  task automatic model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin,
                       output logic [WIDTH-1:0] d, output logic bo, output logic z,
                       output logic ov);
    longint full;
    full = longint'(a) - longint'(b) - longint'(bin);
    d    = WIDTH'(full);
    bo   = (full < 0);
    z    = (d == 0);
`ifdef NIBBLE_SUB_OVERFLOW_EN
    ov   = (a[WIDTH-1] != b[WIDTH-1]) && (d[WIDTH-1] != a[WIDTH-1]);
`else
    ov   = 1'b0;
`endif
  endtask

  // Accept one operation, wait for the result, check latency and outputs.
  task automatic start_and_check(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bin);
    logic [WIDTH-1:0] ed;
    logic eb, ez, eo;
    int n;
    model(a, b, bin, ed, eb, ez, eo);
    check("ready_before_accept", 32'(ready_o), 32'd1);
    a_i = a; b_i = b; borrow_i = bin; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    a_i = WIDTH'($urandom); b_i = WIDTH'($urandom); borrow_i = 1'($urandom);
    check("ready_after_accept", 32'(ready_o), 32'd0);
    n = 0;
    while (valid_o !== 1'b1 && n < 64) begin
      @(posedge clk_i); #1;
      n++;
    end
    check("latency", 32'(n), 32'(NIB));
    check("diff", 32'(diff_o), 32'(ed));
    check("borrow", 32'(borrow_o), 32'(eb));
    check("zero", 32'(zero_o), 32'(ez));
    check("overflow", 32'(overflow_o), 32'(eo));
  endtask

  task automatic release_result();
    ready_i = 1'b1;
    @(posedge clk_i); #1;
    check("valid_after_handoff", 32'(valid_o), 32'd0);
    check("ready_after_handoff", 32'(ready_o), 32'd1);
  endtask

  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
    start_and_check(a, b, bin);
    release_result();
  endtask

  initial begin
    logic [WIDTH-1:0] held_diff;
    logic held_borrow;
    passed = 0; failed = 0; total = 0;
    rst_ni = 1'b0; valid_i = 1'b0; ready_i = 1'b1;
    a_i = '0; b_i = '0; borrow_i = 1'b0;

    #12;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_diff", 32'(diff_o), 32'd0);
    check("rst_borrow", 32'(borrow_o), 32'd0);
    check("rst_zero", 32'(zero_o), 32'd0);
    check("rst_overflow", 32'(overflow_o), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;

    // Directed cases.
    run_op(16'h1234, 16'h0234, 1'b0);
    run_op(16'h0000, 16'h0001, 1'b0);
    run_op(16'h0005, 16'h0005, 1'b1);
    run_op(16'hABCD, 16'hABCD, 1'b0);
    run_op(16'h8000, 16'h0001, 1'b0);
    run_op(16'h7FFF, 16'hFFFF, 1'b0);
    run_op(16'hFFFF, 16'hFFFF, 1'b1);

    // Backpressure in DONE with ignored valid_i pulses.
    ready_i = 1'b0;
    start_and_check(16'h4321, 16'h1234, 1'b1);
    held_diff   = diff_o;
    held_borrow = borrow_o;
    for (int i = 0; i < 5; i++) begin
      valid_i = 1'($urandom);
      a_i = WIDTH'($urandom); b_i = WIDTH'($urandom);
      @(posedge clk_i); #1;
      check("bp_valid", 32'(valid_o), 32'd1);
      check("bp_ready", 32'(ready_o), 32'd0);
      check("bp_diff", 32'(diff_o), 32'(held_diff));
      check("bp_borrow", 32'(borrow_o), 32'(held_borrow));
    end
    valid_i = 1'b0;
    release_result();
    run_op(16'h0000, 16'h0001, 1'b0);

    // Reset during the second RUN cycle aborts the operation.
    a_i = 16'h5555; b_i = 16'h1111; borrow_i = 1'b0; valid_i = 1'b1;
    @(posedge clk_i); #1;
    valid_i = 1'b0;
    @(posedge clk_i); #2;
    rst_ni = 1'b0;
    #1;
    check("abort_ready", 32'(ready_o), 32'd1);
    check("abort_valid", 32'(valid_o), 32'd0);
    check("abort_diff", 32'(diff_o), 32'd0);
    check("abort_borrow", 32'(borrow_o), 32'd0);
    check("abort_zero", 32'(zero_o), 32'd0);
    check("abort_overflow", 32'(overflow_o), 32'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    @(posedge clk_i); #1;
    run_op(16'h0010, 16'h0001, 1'b0);

    // Randomised operands with occasional held-off consumer.
    for (int i = 0; i < 24; i++) begin
      ready_i = 1'($urandom_range(0, 1));
      start_and_check(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
      for (int w = 0; w < int'($urandom_range(0, 3)); w++) begin
        @(posedge clk_i); #1;
        if (ready_i === 1'b0) check("rand_hold_valid", 32'(valid_o), 32'd1);
      end
      release_result();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Multi-cycle subtractor computing `diff = a - b - borrow` on WIDTH-bit operands, one 4-bit slice per clock, LSB slice first. Each slice uses a borrow-lookahead stage. The block is the arithmetic inverse of the team's 4-bit carry-lookahead adder slice. It sits on the datapath as a low-area alternative to a full-width subtractor, with a valid/ready handshake on both sides.

## Interface
- WIDTH, 16, operand width in bits; must be a multiple of 4 and ≥ 4.
- clk_i  input  1  clock; all state updates on rising edge.
- rst_ni  input  1  reset, asynchronous and active-low.
- valid_i  input  1  operands valid.
- ready_o  output  1  block can accept operands.
- a_i  input  WIDTH  minuend.
- b_i  input  WIDTH  subtrahend.
- borrow_i  input  1  incoming borrow; sampled with the operands.
- valid_o  output  1  result valid.
- ready_i  input  1  consumer accepts the result.
- diff_o  output  WIDTH  difference, modulo 2^WIDTH.
- borrow_o  output  1  unsigned borrow out; 1 iff a < b + borrow_i.
- zero_o  output  1  diff_o == 0.
- overflow_o  output  1  signed overflow (see Configuration).

## Operation
- NIB = WIDTH/4. Slice counter is max(1, $clog2(NIB)) bits wide.
- FSM states and transitions:
  - IDLE: ready_o=1. On valid_i & ready_o, latch a_i, b_i, borrow_i, clear the slice counter, clear the diff register, go to RUN.
  - RUN: each cycle, subtract slice k (bits 4k+3:4k) using the current running borrow, write the 4 result bits into the diff register, register the slice borrow, increment k. After slice NIB-1, go to DONE.
  - DONE: valid_o=1. On ready_i, go to IDLE.
- Slice math:
  - p_j = a_j ^ ~b_j; g_j = a_j & ~b_j.
  - Carry-in = ~borrow; lookahead carries are as in a 4-bit CLA.
  - Slice borrow-out = ~carry-out.
- zero_o and overflow_o are registered when entering DONE. Both are derived from the final diff register and the latched operand MSBs.
- ready_o is 1 only in IDLE; no operands are accepted in RUN or DONE.
- valid_i with ready_o=0 is ignored. The upstream source must hold its data.
- diff_o, borrow_o, zero_o and overflow_o hold their values from entry to DONE until the next acceptance. They are not cleared on exit from DONE.

## Timing
- Latency: valid_o rises NIB rising edges after the accepting edge. Throughput is one operation per NIB+2 cycles with ready_i held high.
- Reset values, all asserted asynchronously on rst_ni=0:
  - state = IDLE, so ready_o = 1.
  - valid_o = 0, diff_o = 0, borrow_o = 0, zero_o = 0, overflow_o = 0.
  - slice counter = 0.
- Reset during RUN or DONE aborts the operation; no partial result is ever presented.
- On release of reset, the block is in IDLE and can accept on the first edge.
- In DONE with ready_i held low, all outputs stay stable indefinitely.
- WIDTH=4: RUN lasts exactly one cycle.
- Borrow chain wraps at bit WIDTH-1; no extension bits are produced.

## Configuration
- Macro: NIBBLE_SUB_OVERFLOW_EN.
- Defined: overflow_o = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), registered on entry to DONE.
- Undefined: the overflow logic is not built; overflow_o is tied to 0. The port exists in both builds.

## Structure
- The shared package holds:
  - the FSM state enum {IDLE, RUN, DONE};
  - the constant SLICE_W = 4;
  - a function computing the slice-counter width from WIDTH.
- One sub-module: sub4_borrow_la.
  - Inputs: a[3:0], b[3:0], borrow_in.
  - Outputs: diff[3:0], borrow_out.
  - Purely combinational, built on lookahead terms.
- The top level holds the FSM, operand/diff registers, counter, flags and handshake.

## Test plan
- WIDTH=16, a=0x1234, b=0x0234, borrow_i=0 → valid_o rises 4 edges after accept; diff_o=0x1000, borrow_o=0, zero_o=0, overflow_o=0.
- a=0x0000, b=0x0001 → diff_o=0xFFFF, borrow_o=1. Then a=0x0005, b=0x0005, borrow_i=1 → diff_o=0xFFFF, borrow_o=1.
- a=0xABCD, b=0xABCD, borrow_i=0 → diff_o=0x0000, zero_o=1, borrow_o=0.
- a=0x8000, b=0x0001 → diff_o=0x7FFF, borrow_o=0. overflow_o=1 with NIBBLE_SUB_OVERFLOW_EN defined, 0 without.
- Backpressure: hold ready_i=0 for 5 cycles in DONE → valid_o stays 1, ready_o stays 0, outputs stable. valid_i pulses during that window are ignored. After ready_i=1, the next operation completes correctly.
- Pull rst_ni low in the second RUN cycle → all outputs reset immediately and ready_o=1. After release, a=0x0010, b=0x0001 → diff_o=0x000F.
